vga_sync_gen: RTL

//  Downstream timing stage fed by the clock-wizard pixel clock. Counts pixels and lines

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_axis_fsm.sv | 67 ++++++
 rtl/vga_sync_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, phase encoding and test-pattern colour table.
// The colour table is only referenced when VGA_TEST_PATTERN_EN is defined.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Eight 128-pixel-wide vertical bars selected by the top three bits of the x coordinate.
  function automatic logic [11:0] barColour(input logic [9:0] x);
    logic [11:0] colour;
    case (x[9:7])
      3'd0:    colour = 12'hFFF;
      3'd1:    colour = 12'hFF0;
      3'd2:    colour = 12'h0FF;
      3'd3:    colour = 12'h0F0;
      3'd4:    colour = 12'hF0F;
      3'd5:    colour = 12'hF00;
      3'd6:    colour = 12'h00F;
      default: colour = 12'h000;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK phase.
// Exposes the next phase so the parent can register outputs on the same edge as the count.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int CW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  output logic [CW-1:0] cnt_o,
  output phase_e        phaseNext_o,
  output logic          wrap_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST_ACTIVE = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] LAST_FRONT  = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] LAST_SYNC   = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] LAST        = CW'(TOTAL - 1);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : gBadPorch
    $error("vga_axis_fsm: every phase length must be at least one");
  end
  if (TOTAL > (2 ** CW)) begin : gBadWidth
    $error("vga_axis_fsm: CW too narrow for the axis total");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  phase_e        phase_q, phase_d;
  logic          wrap;

  assign wrap = adv_i && (cnt_q == LAST);

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (adv_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      case (phase_q)
        PH_ACTIVE: if (cnt_q == LAST_ACTIVE) phase_d = PH_FRONT;
        PH_FRONT:  if (cnt_q == LAST_FRONT)  phase_d = PH_SYNC;
        PH_SYNC:   if (cnt_q == LAST_SYNC)   phase_d = PH_BACK;
        default:   if (cnt_q == LAST)        phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign phaseNext_o = phase_d;
  assign wrap_o      = wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// Porch-accurate VGA timing engine: H and V axis counters with registered sync/blank/pulse outputs.
// Optional colour-bar generator on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0]   rgb
`endif
);

  phase_e hPhaseNext, vPhaseNext;
  logic   hWrap, vWrap;
  logic   hsync_q, vsync_q, videoOn_q, lineStart_q, frameStart_q;
  logic   videoOn_d;

  vga_axis_fsm #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) uHAxis (
    .clk_i       (clk),
    .rst_i       (rst),
    .adv_i       (en),
    .cnt_o       (pix_x),
    .phaseNext_o (hPhaseNext),
    .wrap_o      (hWrap)
  );

  // The vertical axis steps once per completed line.
  vga_axis_fsm #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) uVAxis (
    .clk_i       (clk),
    .rst_i       (rst),
    .adv_i       (hWrap),
    .cnt_o       (pix_y),
    .phaseNext_o (vPhaseNext),
    .wrap_o      (vWrap)
  );

  assign videoOn_d = (hPhaseNext == PH_ACTIVE) && (vPhaseNext == PH_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      videoOn_q    <= 1'b1;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      hsync_q      <= (hPhaseNext == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_q      <= (vPhaseNext == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      videoOn_q    <= videoOn_d;
      lineStart_q  <= hWrap;
      frameStart_q <= vWrap;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = videoOn_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [CW-1:0] hNext;
  logic [11:0]   rgb_q;

  // Colour is looked up from the x the counter is about to take, keeping rgb aligned with pix_x.
  assign hNext = hWrap ? '0 : pix_x + CW'(en);

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= videoOn_d ? barColour(10'(hNext)) : 12'h000;
    end
  end

  assign rgb = rgb_q;
`endif

endmodule
